// File: rtl/lib_allocator_pkg.sv
// Shared types and sizing helpers for the iSLIP allocator and its priority arbiters.
package lib_allocator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITERATE = 2'd1,
        ST_DONE    = 2'd2
    } alloc_state_e;

    // Holds iteration indices 0..3; ITER tops out at 4.
    localparam int ITER_CNT_W = 2;

    // Binary pointer width for a K-way round-robin; a 1-way port still gets one bit.
    function automatic int ptr_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/lib_ppe_ptr.sv
// Combinational programmable priority arbiter: grants the first set request at or
// after a binary pointer, wrapping around, as a one-hot (or zero) vector.
module lib_ppe_ptr
    import lib_allocator_pkg::*;
#(
    parameter int K  = 4,
    parameter int PW = ptr_width(K)
) (
    input  logic [K-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [K-1:0]  grant
);

    logic found;

    // Two passes: indices at/after the pointer first, then the wrapped low indices.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < K; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lib_allocator_islip.sv
// iSLIP N x M allocator: captures a request matrix, runs ITER grant/accept rounds
// (one per cycle) and presents the match matrix. Optional LIB_ALLOCATOR_ISLIP_STATS_EN adds o_match_count.
module lib_allocator_islip
    import lib_allocator_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int ITER = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [N-1:0][0:M-1]  i_request,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [N-1:0][0:M-1]  o_grant
`ifdef LIB_ALLOCATOR_ISLIP_STATS_EN
    ,
    output logic [31:0]          o_match_count
`endif
);

    localparam int PW_N = ptr_width(N);
    localparam int PW_M = ptr_width(M);

    alloc_state_e             state_reg;
    logic [ITER_CNT_W-1:0]    iter_cnt_reg;
    logic [N-1:0][0:M-1]      req_reg;
    logic [N-1:0][0:M-1]      match_reg;
    logic [N-1:0][0:M-1]      first_acc_reg;
    logic [M-1:0][PW_N-1:0]   gptr_reg;
    logic [N-1:0][PW_M-1:0]   aptr_reg;
    logic [M-1:0][PW_N-1:0]   gptr_next;
    logic [N-1:0][PW_M-1:0]   aptr_next;

    logic [N-1:0]             in_matched;
    logic [M-1:0]             out_matched;
    logic [M-1:0][N-1:0]      out_req;
    logic [M-1:0][N-1:0]      out_gnt;
    logic [N-1:0][M-1:0]      in_gnt;
    logic [N-1:0][M-1:0]      in_acc;
    logic [N-1:0][0:M-1]      accept;
    logic [N-1:0][0:M-1]      first_acc;
    logic                     last_iter;

    genvar gi;

    // Requests involving an already-matched port drop out of later rounds.
    always_comb begin
        in_matched  = '0;
        out_matched = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                in_matched[i]  = in_matched[i]  | match_reg[i][j];
                out_matched[j] = out_matched[j] | match_reg[i][j];
            end
        end
    end

    always_comb begin
        out_req = '0;
        in_gnt  = '0;
        accept  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                out_req[j][i] = req_reg[i][j] & ~in_matched[i] & ~out_matched[j];
                in_gnt[i][j]  = out_gnt[j][i];
                accept[i][j]  = in_acc[i][j];
            end
        end
    end

    generate
        for (gi = 0; gi < M; gi++) begin : g_grant
            lib_ppe_ptr #(.K(N), .PW(PW_N)) u_grant (
                .req   (out_req[gi]),
                .ptr   (gptr_reg[gi]),
                .grant (out_gnt[gi])
            );
        end
        for (gi = 0; gi < N; gi++) begin : g_accept
            lib_ppe_ptr #(.K(M), .PW(PW_M)) u_accept (
                .req   (in_gnt[gi]),
                .ptr   (aptr_reg[gi]),
                .grant (in_acc[gi])
            );
        end
    endgenerate

    assign last_iter = (iter_cnt_reg == ITER_CNT_W'(ITER - 1));
    // With a single round the first-round accepts are only available combinationally.
    assign first_acc = (iter_cnt_reg == '0) ? accept : first_acc_reg;

    always_comb begin
        gptr_next = gptr_reg;
        aptr_next = aptr_reg;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                if (first_acc[i][j]) begin
                    gptr_next[j] = PW_N'((i + 1) % N);
                    aptr_next[i] = PW_M'((j + 1) % M);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            iter_cnt_reg  <= '0;
            req_reg       <= '0;
            match_reg     <= '0;
            first_acc_reg <= '0;
            gptr_reg      <= '0;
            aptr_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        req_reg       <= i_request;
                        match_reg     <= '0;
                        first_acc_reg <= '0;
                        iter_cnt_reg  <= '0;
                        state_reg     <= ST_ITERATE;
                    end
                end
                ST_ITERATE: begin
                    match_reg    <= match_reg | accept;
                    iter_cnt_reg <= iter_cnt_reg + ITER_CNT_W'(1);
                    if (iter_cnt_reg == '0) begin
                        first_acc_reg <= accept;
                    end
                    if (last_iter) begin
                        gptr_reg  <= gptr_next;
                        aptr_reg  <= aptr_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = (state_reg == ST_IDLE);
    assign o_valid = (state_reg == ST_DONE);
    assign o_grant = o_valid ? match_reg : '0;

`ifdef LIB_ALLOCATOR_ISLIP_STATS_EN
    logic [31:0] match_count_reg;
    logic [31:0] grant_pop;
    logic [32:0] count_sum;

    always_comb begin
        grant_pop = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                grant_pop = grant_pop + 32'(o_grant[i][j]);
            end
        end
        count_sum = {1'b0, match_count_reg} + {1'b0, grant_pop};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            match_count_reg <= '0;
        end else if (o_valid && i_ready) begin
            match_count_reg <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
        end
    end

    assign o_match_count = match_count_reg;
`endif

endmodule

// File: tb/tb_lib_allocator_islip.sv
// Randomized self-checking bench for lib_allocator_islip (N=M=4, ITER=2) against a
// round-based iSLIP reference model; also checks the match counter when enabled.
module tb_lib_allocator_islip;

    localparam int N    = 4;
    localparam int M    = 4;
    localparam int ITER = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                i_valid;
    logic                o_ready;
    logic [N-1:0][0:M-1] i_request;
    logic                o_valid;
    logic                i_ready;
    logic [N-1:0][0:M-1] o_grant;
`ifdef LIB_ALLOCATOR_ISLIP_STATS_EN
    logic [31:0]         o_match_count;
    int                  exp_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference pointers: output j's grant pointer, input i's accept pointer.
    int gp[M];
    int ap[N];

    always #5 clk = ~clk;

    lib_allocator_islip #(.N(N), .M(M), .ITER(ITER)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_request (i_request),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_grant   (o_grant)
`ifdef LIB_ALLOCATOR_ISLIP_STATS_EN
        ,
        .o_match_count (o_match_count)
`endif
    );

    // Reference iSLIP: ITER rounds of grant/accept; only round-one accepts move pointers.
    function automatic logic [N-1:0][0:M-1] model_alloc(input logic [N-1:0][0:M-1] req);
        logic [N-1:0][0:M-1] res;
        bit in_m[N];
        bit out_m[M];
        int granted_to[M];
        int new_gp[M];
        int new_ap[N];
        bit done;
        res = '0;
        for (int i = 0; i < N; i++) begin in_m[i] = 0; new_ap[i] = ap[i]; end
        for (int j = 0; j < M; j++) begin out_m[j] = 0; new_gp[j] = gp[j]; end
        for (int it = 0; it < ITER; it++) begin
            for (int j = 0; j < M; j++) begin
                granted_to[j] = -1;
                if (!out_m[j]) begin
                    done = 0;
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (gp[j] + k) % N;
                        if (!done && !in_m[i] && req[i][j]) begin
                            granted_to[j] = i;
                            done = 1;
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!in_m[i]) begin
                    done = 0;
                    for (int k = 0; k < M; k++) begin
                        int j;
                        j = (ap[i] + k) % M;
                        if (!done && granted_to[j] == i) begin
                            done      = 1;
                            res[i][j] = 1'b1;
                            in_m[i]   = 1;
                            out_m[j]  = 1;
                            if (it == 0) begin
                                new_gp[j] = (i + 1) % N;
                                new_ap[i] = (j + 1) % M;
                            end
                        end
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) ap[i] = new_ap[i];
        for (int j = 0; j < M; j++) gp[j] = new_gp[j];
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) ap[i] = 0;
        for (int j = 0; j < M; j++) gp[j] = 0;
`ifdef LIB_ALLOCATOR_ISLIP_STATS_EN
        exp_count = 0;
`endif
    endtask

    // Full transaction from IDLE: capture, wait for o_valid, hold 'hold' cycles, consume.
    task automatic alloc(input string tag, input logic [N-1:0][0:M-1] req, input int hold,
                         output logic [N-1:0][0:M-1] got);
        logic [N-1:0][0:M-1] exp;
        logic [N-1:0][0:M-1] held;
        int lat;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_before got=%b exp=1", tag, o_ready);
        end
        i_valid   = 1'b1;
        i_request = req;
        i_ready   = 1'b0;
        @(negedge clk);
        i_valid   = 1'b0;
        i_request = $urandom;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        exp = model_alloc(req);
        got = o_grant;
        n_checks++;
        if (lat != ITER) begin
            n_fail++;
            $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, ITER);
        end
        n_checks++;
        if (o_grant !== exp) begin
            n_fail++;
            $display("FAIL %s_grant req=%b got=%b exp=%b", tag, req, o_grant, exp);
        end
        held = o_grant;
        for (int c = 0; c < hold; c++) begin
            i_valid   = 1'($urandom);
            i_request = $urandom;
            @(negedge clk);
            n_checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_grant !== held) begin
                n_fail++;
                $display("FAIL %s_hold cyc=%0d valid=%b ready=%b got=%b exp=%b",
                         tag, c, o_valid, o_ready, o_grant, held);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
`ifdef LIB_ALLOCATOR_ISLIP_STATS_EN
        exp_count += $countones(exp);
        n_checks++;
        if (o_match_count !== 32'(exp_count)) begin
            n_fail++;
            $display("FAIL %s_count got=%0d exp=%0d", tag, o_match_count, exp_count);
        end
`endif
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_grant !== '0) begin
            n_fail++;
            $display("FAIL %s_consume ready=%b valid=%b grant=%b exp ready=1 valid=0 grant=0",
                     tag, o_ready, o_valid, o_grant);
        end
        $display("txn %s req=%b grant=%b lat=%0d hold=%0d", tag, req, got, lat, hold);
    endtask

    task automatic check_ptrs(input string tag);
        for (int j = 0; j < M; j++) begin
            n_checks++;
            if (dut.gptr_reg[j] !== 2'(gp[j])) begin
                n_fail++;
                $display("FAIL %s_gptr%0d got=%0d exp=%0d", tag, j, dut.gptr_reg[j], gp[j]);
            end
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (dut.aptr_reg[i] !== 2'(ap[i])) begin
                n_fail++;
                $display("FAIL %s_aptr%0d got=%0d exp=%0d", tag, i, dut.aptr_reg[i], ap[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_request = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_grant !== '0) begin
            n_fail++;
            $display("FAIL reset ready=%b valid=%b grant=%b exp ready=1 valid=0 grant=0",
                     o_ready, o_valid, o_grant);
        end
        check_ptrs("reset");
        $display("txn reset ready=%b valid=%b", o_ready, o_valid);
    endtask

    task automatic test_all_ones(input string tag);
        logic [N-1:0][0:M-1] got;
        logic [N-1:0][0:M-1] exp1;
        logic [N-1:0][0:M-1] exp2;
        exp1 = '0;
        exp1[0] = 4'b1000;
        exp1[1] = 4'b0100;
        exp2 = '0;
        exp2[0] = 4'b0100;
        exp2[1] = 4'b1000;
        exp2[2] = 4'b0010;
        alloc({tag, "_first"}, '1, 0, got);
        n_checks++;
        if (got !== exp1) begin
            n_fail++;
            $display("FAIL %s_first_const got=%b exp=%b", tag, got, exp1);
        end
        n_checks++;
        if (dut.gptr_reg[0] !== 2'd1 || dut.aptr_reg[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL %s_first_ptr gptr0=%0d aptr0=%0d exp 1 1", tag,
                     dut.gptr_reg[0], dut.aptr_reg[0]);
        end
        alloc({tag, "_repeat"}, '1, 1, got);
        n_checks++;
        if (got !== exp2) begin
            n_fail++;
            $display("FAIL %s_repeat_const got=%b exp=%b", tag, got, exp2);
        end
        check_ptrs(tag);
    endtask

    task automatic test_single();
        logic [N-1:0][0:M-1] req;
        logic [N-1:0][0:M-1] exp;
        logic [N-1:0][0:M-1] got;
        req = '0;
        req[2] = 4'b0001;
        exp = req;
        alloc("single", req, 0, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL single_const got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_hold();
        logic [N-1:0][0:M-1] got;
        logic [N-1:0][0:M-1] req;
        req = 16'hA5C3;
        alloc("hold", req, 5, got);
        check_ptrs("hold");
    endtask

    task automatic test_zero();
        logic [N-1:0][0:M-1] got;
        alloc("zero", '0, 2, got);
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL zero_const got=%b exp=0", got);
        end
        check_ptrs("zero");
    endtask

    task automatic test_random();
        logic [N-1:0][0:M-1] got;
        logic [N-1:0][0:M-1] req;
        for (int t = 0; t < 40; t++) begin
            req = (t % 3 == 0) ? 16'($urandom) : 16'($urandom & $urandom | $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) begin
                // i_ready while idle must not disturb anything
                i_ready = 1'b1;
                @(negedge clk);
                i_ready = 1'b0;
                n_checks++;
                if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_idle_ready valid=%b ready=%b exp valid=0 ready=1",
                             o_valid, o_ready);
                end
            end
            alloc("rnd", req, $urandom_range(0, 3), got);
        end
        check_ptrs("rnd");
    endtask

    task automatic test_reset_mid();
        i_valid   = 1'b1;
        i_request = '1;
        @(negedge clk);
        i_valid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_grant !== '0) begin
            n_fail++;
            $display("FAIL reset_mid ready=%b valid=%b grant=%b exp ready=1 valid=0 grant=0",
                     o_ready, o_valid, o_grant);
        end
        check_ptrs("reset_mid");
        test_all_ones("post_reset");
`ifdef LIB_ALLOCATOR_ISLIP_STATS_EN
        n_checks++;
        if (o_match_count !== 32'd5) begin
            n_fail++;
            $display("FAIL match_count got=%0d exp=5", o_match_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_all_ones("ones");
        test_single();
        test_hold();
        test_zero();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout no completion");
        $fatal(1, "timeout");
    end

endmodule
